// File: rtl/wbfm_audio_decimator.sv
// Boxcar decimator behind the wbfm core's ap_fifo output. It averages each stereo channel over
// 2^DECIM_LOG2 samples and writes one word per block to the downstream read FIFO.
module wbfm_audio_decimator #(
  parameter int unsigned DECIM_LOG2 = 2
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        clr,
  input  logic [31:0] in_din,
  input  logic        in_write,
  output logic        in_full_n,
  output logic [31:0] out_din,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic        err_ovf,
  output logic [31:0] words_out
);

  localparam int unsigned AW = 16 + DECIM_LOG2;
  // With D = 1 the block counter carries no information; keep one bit so nothing is zero-width.
  localparam int unsigned CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0] CntLast = CW'((1 << DECIM_LOG2) - 1);

  logic signed [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic        [31:0]   out_data_q, out_data_d;
  logic                 err_q, err_d;
  logic        [31:0]   words_q, words_d;

  logic signed [15:0]   s_l, s_r;
  logic signed [AW-1:0] sum_l, sum_r, avg_l, avg_r;
  logic                 drain, accept, last;

  assign s_l = in_din[31:16];
  assign s_r = in_din[15:0];
  assign sum_l = acc_l_q + AW'(s_l);
  assign sum_r = acc_r_q + AW'(s_r);
  assign avg_l = sum_l >>> DECIM_LOG2;
  assign avg_r = sum_r >>> DECIM_LOG2;

  assign out_wr_en = out_valid_q && !out_full;
  assign drain     = out_wr_en;
  assign in_full_n = !out_valid_q || !out_full;
  assign accept    = in_write && in_full_n;
  assign last      = (cnt_q == CntLast);

  assign out_din   = out_data_q;
  assign err_ovf   = err_q;
  assign words_out = words_q;

  always_comb begin
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    words_d     = words_q;

    if (drain) begin
      out_valid_d = 1'b0;
      words_d     = words_q + 32'd1;
    end

    // A final sample may reload the output register in the same cycle it drains.
    if (accept) begin
      if (last) begin
        out_data_d  = {avg_l[15:0], avg_r[15:0]};
        out_valid_d = 1'b1;
        acc_l_d     = '0;
        acc_r_d     = '0;
        cnt_d       = '0;
      end else begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        cnt_d   = cnt_q + CW'(1);
      end
    end

    if (in_write && !in_full_n) begin
      err_d = 1'b1;
    end

    // clr leaves the sticky error alone and overrides any simultaneous accept.
    if (clr) begin
      acc_l_d     = '0;
      acc_r_d     = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      words_d     = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      words_q     <= '0;
    end else begin
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      words_q     <= words_d;
    end
  end

endmodule

// File: tb/tb_wbfm_audio_decimator.sv
// Bench for wbfm_audio_decimator: directed scenarios for D = 4 and D = 1, plus a randomized run
// checked against a transaction-level block-averaging model.
module tb_wbfm_audio_decimator;

  logic        clk;
  logic        rst_n, clr, wr, full;
  logic [31:0] din;
  logic        full_n, owr, ovf;
  logic [31:0] odin, wout;

  logic        p_rst_n, p_clr, p_wr, p_full;
  logic [31:0] p_din;
  logic        p_full_n, p_owr, p_ovf;
  logic [31:0] p_odin, p_wout;

  int errors = 0;
  int checks = 0;

  wbfm_audio_decimator #(.DECIM_LOG2(2)) dut4 (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .clr       (clr),
    .in_din    (din),
    .in_write  (wr),
    .in_full_n (full_n),
    .out_din   (odin),
    .out_wr_en (owr),
    .out_full  (full),
    .err_ovf   (ovf),
    .words_out (wout)
  );

  wbfm_audio_decimator #(.DECIM_LOG2(0)) dut1 (
    .ap_clk    (clk),
    .ap_rst_n  (p_rst_n),
    .clr       (p_clr),
    .in_din    (p_din),
    .in_write  (p_wr),
    .in_full_n (p_full_n),
    .out_din   (p_odin),
    .out_wr_en (p_owr),
    .out_full  (p_full),
    .err_ovf   (p_ovf),
    .words_out (p_wout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Floor division of a channel sum by the block length, truncated to 16 bits.
  function automatic logic [15:0] favg(input int sum, input int d);
    int q;
    q = sum / d;
    if ((sum % d != 0) && (sum < 0)) q = q - 1;
    return q[15:0];
  endfunction

  function automatic int hi(input logic [31:0] w);
    logic signed [15:0] s;
    s = w[31:16];
    return int'(s);
  endfunction

  function automatic int lo(input logic [31:0] w);
    logic signed [15:0] s;
    s = w[15:0];
    return int'(s);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    wr = 1'b0; clr = 1'b0; full = 1'b0; din = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic w, input logic [31:0] d, input logic f);
    @(negedge clk);
    wr = w; din = d; full = f;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; full = 1'b0; din = '0;
    p_rst_n = 1'b0; p_clr = 1'b0; p_wr = 1'b0; p_full = 1'b0; p_din = '0;
    #12;
    checks++; if (full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n: got %b expected 1", full_n); end
    checks++; if (owr !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", owr); end
    checks++; if (odin !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", odin); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (wout !== 32'h0) begin errors++; $display("FAIL reset_words: got %h expected 0", wout); end
    rst_n = 1'b1; p_rst_n = 1'b1;
  endtask

  task automatic test_average();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {16'(100 * (i + 1)), 16'(-(i + 1))}, 1'b0);
      checks++; if (owr !== 1'b0) begin errors++; $display("FAIL avg_early_wr: got %b expected 0", owr); end
    end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (owr !== 1'b1) begin errors++; $display("FAIL avg_wr: got %b expected 1", owr); end
    checks++; if (odin !== 32'h00FAFFFD) begin errors++; $display("FAIL avg_dout: got %h expected 00fafffd", odin); end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (owr !== 1'b0) begin errors++; $display("FAIL avg_single_wr: got %b expected 0", owr); end
    checks++; if (wout !== 32'd1) begin errors++; $display("FAIL avg_words: got %0d expected 1", wout); end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h7FFF8000, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (owr !== 1'b1) begin errors++; $display("FAIL ext_wr: got %b expected 1", owr); end
    checks++; if (odin !== 32'h7FFF8000) begin errors++; $display("FAIL ext_dout: got %h expected 7fff8000", odin); end
  endtask

  task automatic test_stream();
    logic [31:0] sw [16];
    logic [31:0] exp_w [4];
    int sl, sr;
    do_reset();
    for (int i = 0; i < 16; i++) sw[i] = $urandom;
    for (int b = 0; b < 4; b++) begin
      sl = 0; sr = 0;
      for (int j = 0; j < 4; j++) begin sl += hi(sw[4*b+j]); sr += lo(sw[4*b+j]); end
      exp_w[b] = {favg(sl, 4), favg(sr, 4)};
    end
    for (int i = 0; i < 17; i++) begin
      drive(i < 16, (i < 16) ? sw[i % 16] : 32'h0, 1'b0);
      checks++; if (full_n !== 1'b1) begin errors++; $display("FAIL stream_full_n: cyc %0d got %b expected 1", i, full_n); end
      checks++;
      if (owr !== (i >= 4 && i % 4 == 0)) begin
        errors++; $display("FAIL stream_wr: cyc %0d got %b expected %b", i, owr, (i >= 4 && i % 4 == 0));
      end
      if (i >= 4 && i % 4 == 0) begin
        checks++;
        if (odin !== exp_w[i/4-1]) begin
          errors++; $display("FAIL stream_dout: blk %0d got %h expected %h", i/4-1, odin, exp_w[i/4-1]);
        end
      end
    end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (wout !== 32'd4) begin errors++; $display("FAIL stream_words: got %0d expected 4", wout); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0028FFD8, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    checks++; if (full_n !== 1'b0) begin errors++; $display("FAIL bp_full_n: got %b expected 0", full_n); end
    checks++; if (owr !== 1'b0) begin errors++; $display("FAIL bp_wr_held: got %b expected 0", owr); end
    drive(1'b1, 32'h7FFF7FFF, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b expected 1", ovf); end
    checks++; if (odin !== 32'h0028FFD8) begin errors++; $display("FAIL bp_stable: got %h expected 0028ffd8", odin); end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (owr !== 1'b1) begin errors++; $display("FAIL bp_release_wr: got %b expected 1", owr); end
    checks++; if (odin !== 32'h0028FFD8) begin errors++; $display("FAIL bp_release_dout: got %h expected 0028ffd8", odin); end
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0004FFFC, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (odin !== 32'h0004FFFC) begin errors++; $display("FAIL bp_next_blk: got %h expected 0004fffc", odin); end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (wout !== 32'd2) begin errors++; $display("FAIL bp_words: got %0d expected 2", wout); end
  endtask

  // Runs right after test_backpressure so err_ovf is already set and must survive clr.
  task automatic test_clr();
    drive(1'b1, 32'h03E803E8, 1'b0);
    drive(1'b1, 32'h03E803E8, 1'b0);
    @(negedge clk); wr = 1'b0; clr = 1'b1; #1;
    @(negedge clk); clr = 1'b0; #1;
    checks++; if (wout !== 32'd0) begin errors++; $display("FAIL clr_words: got %0d expected 0", wout); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_keeps_ovf: got %b expected 1", ovf); end
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h00080008, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (owr !== 1'b1) begin errors++; $display("FAIL clr_wr: got %b expected 1", owr); end
    checks++; if (odin !== 32'h00080008) begin errors++; $display("FAIL clr_dout: got %h expected 00080008", odin); end
  endtask

  task automatic test_passthrough();
    logic [31:0] pw [2];
    pw[0] = 32'h12345678; pw[1] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p_wr = (i < 2); p_din = (i < 2) ? pw[i % 2] : 32'h0;
      #1;
      if (i > 0) begin
        checks++; if (p_owr !== 1'b1) begin errors++; $display("FAIL pass_wr: word %0d got %b expected 1", i-1, p_owr); end
        checks++; if (p_odin !== pw[i-1]) begin errors++; $display("FAIL pass_dout: got %h expected %h", p_odin, pw[i-1]); end
      end
    end
    @(negedge clk); #1;
    checks++; if (p_wout !== 32'd2) begin errors++; $display("FAIL pass_words: got %0d expected 2", p_wout); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut1.words_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut1.words_q;
    #1;
    checks++; if (p_wout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", p_wout); end
    @(negedge clk); p_wr = 1'b1; p_din = 32'hCAFE0001;
    @(negedge clk); p_wr = 1'b0; #1;
    checks++; if (p_owr !== 1'b1) begin errors++; $display("FAIL wrap_wr: got %b expected 1", p_owr); end
    @(negedge clk); #1;
    checks++; if (p_wout !== 32'h0) begin errors++; $display("FAIL wrap_words: got %h expected 0", p_wout); end
  endtask

  // Randomized traffic against a model that only knows about blocks, one pending word and counts.
  task automatic test_random();
    bit          pend = 0, m_ovf = 0, exp_fn, exp_wr;
    logic [31:0] m_word = '0;
    int          sl = 0, sr = 0, n = 0;
    int unsigned m_words = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      clr  = ($urandom_range(0, 39) == 0);
      wr   = !clr && ($urandom_range(0, 3) != 0);
      din  = $urandom;
      full = ($urandom_range(0, 3) == 0);
      #1;
      exp_fn = !(pend && full);
      exp_wr = pend && !full;
      checks++; if (full_n !== exp_fn) begin errors++; $display("FAIL rnd_full_n: cyc %0d got %b expected %b", c, full_n, exp_fn); end
      checks++; if (owr !== exp_wr) begin errors++; $display("FAIL rnd_wr: cyc %0d got %b expected %b", c, owr, exp_wr); end
      if (exp_wr) begin
        checks++; if (odin !== m_word) begin errors++; $display("FAIL rnd_dout: cyc %0d got %h expected %h", c, odin, m_word); end
      end
      checks++; if (wout !== m_words) begin errors++; $display("FAIL rnd_words: cyc %0d got %0d expected %0d", c, wout, m_words); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf: cyc %0d got %b expected %b", c, ovf, m_ovf); end
      if (clr) begin
        pend = 0; sl = 0; sr = 0; n = 0; m_words = 0; m_word = '0;
      end else begin
        if (exp_wr) begin pend = 0; m_words++; end
        if (wr && !exp_fn) m_ovf = 1;
        if (wr && exp_fn) begin
          sl += hi(din); sr += lo(din); n++;
          if (n == 4) begin
            m_word = {favg(sl, 4), favg(sr, 4)};
            pend = 1; sl = 0; sr = 0; n = 0;
          end
        end
      end
    end
    // Asynchronous reset in the middle of a cycle clears everything at once.
    @(negedge clk);
    wr = 1'b1; din = 32'h11112222; full = 1'b1; clr = 1'b0;
    #2; rst_n = 1'b0; #1;
    checks++; if (full_n !== 1'b1) begin errors++; $display("FAIL arst_full_n: got %b expected 1", full_n); end
    checks++; if (odin !== 32'h0) begin errors++; $display("FAIL arst_dout: got %h expected 0", odin); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b expected 0", ovf); end
    checks++; if (wout !== 32'h0) begin errors++; $display("FAIL arst_words: got %h expected 0", wout); end
    wr = 1'b0; full = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_average();
    test_extremes();
    test_stream();
    test_backpressure();
    test_clr();
    test_passthrough();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wbfm_audio_decimator.md
Name: wbfm_audio_decimator

Overview:
- Downstream neighbour of the wbfm HLS core. Presents an ap_fifo write-side target to the core's out_r port: consumes 32-bit stereo sample words.
- Boxcar-averages each channel over 2^DECIM_LOG2 samples and writes one averaged word per block into the FIFO write port that feeds /dev/xillybus_read_32.
- Provides backpressure to the core, a sticky protocol-error flag and an emitted-word counter.

Parameters:
- DECIM_LOG2, 2, log2 of the decimation factor D; legal range 0..8; D = 1 is a registered pass-through.

Ports:
- ap_clk  in  1  clock (bus_clk domain)
- ap_rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear (tied to !user_r_read_32_open); same effect as reset, except it has no effect on err_ovf
- in_din  in  32  sample word: [31:16] left, [15:0] right, signed two's complement
- in_write  in  1  core write strobe
- in_full_n  out  1  high = block can accept a word this cycle
- out_din  out  32  averaged word, same packing as in_din
- out_wr_en  out  1  write strobe to downstream FIFO
- out_full  in  1  downstream FIFO full
- err_ovf  out  1  sticky: in_write seen while in_full_n low
- words_out  out  32  count of words written downstream

Behaviour:
- Reset (async, ap_rst_n low) clears all state:
  - acc_l = acc_r = 0, cnt = 0, out_valid = 0, out_data = 0, err_ovf = 0, words_out = 0.
  - Outputs after reset: in_full_n = 1, out_wr_en = 0, out_din = 0.
- Output stage is a single register with valid flag out_valid.
  - out_din = out_data; out_wr_en = out_valid && !out_full (combinational).
  - drain = out_wr_en; when drain fires, out_valid clears unless reloaded that cycle.
- Input handshake: in_full_n = !out_valid || !out_full (combinational; no dependency on in_write). accept = in_write && in_full_n.
- Accumulators: acc_l and acc_r are signed, 16+DECIM_LOG2 bits, sign-extended adds; cnt is DECIM_LOG2 bits.
- On accept with cnt != D-1: acc += sample per channel; cnt++.
- On accept with cnt == D-1 (final sample of a block):
  - out_data = {(acc_l + s_l) >>> DECIM_LOG2, (acc_r + s_r) >>> DECIM_LOG2}, low 16 bits of each result.
  - Shift is arithmetic, i.e. floor rounding.
  - out_valid <= 1; acc reset to 0; cnt <= 0.
- A final sample is accepted in the same cycle as a drain of the previous word (back-to-back, no bubble).
- Latency: final sample accepted at cycle t → out_wr_en high at t+1 if !out_full; held with stable out_din until out_full deasserts.
- Throughput: 1 input word/cycle sustained while the downstream FIFO is not full.
- D = 1: every accepted word is registered unchanged to out_data.
- words_out increments on each out_wr_en; wraps at 2^32 (0xFFFFFFFF → 0).
- err_ovf sets when in_write && !in_full_n. The word is dropped; no other state changes. Cleared only by ap_rst_n.
- clr mid-block discards partial accumulation and any pending out_valid word; clr has priority over a simultaneous accept.
- Reset asserted mid-operation: all state cleared immediately, asynchronously; the partial block is lost.
- No dropping of accepted words under backpressure; an accepted word always contributes to exactly one output.

Test Plan:
- D = 4: feed left 100,200,300,400 and right -1,-2,-3,-4 → one out_wr_en, out_din = 0x00FAFFFD (250, -3 floor); words_out = 1.
- Extremes, D = 4: four words 0x7FFF8000 → out_din = 0x7FFF8000 (no overflow in widened acc).
- Continuous stream of 16 words, out_full = 0 → 4 outputs, each one cycle after its final sample; in_full_n stays 1 throughout.
- out_full = 1 while an output is pending → in_full_n = 0, out_din stable. Drive in_write in that state → err_ovf = 1, word dropped. Release out_full → word written; next block average unaffected by the dropped word.
- Assert clr after 2 of 4 samples, then feed 4 samples of 8/8 → out_din = 0x00080008, not a mix with the earlier samples.
- DECIM_LOG2 = 0: words 0x12345678, 0xDEADBEEF → identical out_din, each 1 cycle later. Preload words_out = 0xFFFFFFFF by forcing → wraps to 0 on the next write.
